// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush scheduler: drives PC enable and per-stage enable/clear from load-use, redirect, mul/div and memory-wait.
// Optional perf counters under `define PIPE_CTRL_PERF_EN. Outputs are combinational (same-cycle stall); state updates on posedge.
module pipe_ctrl #(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int PERF_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_rs1_use,
  input  logic              i_id_rs2_use,
  input  logic              i_ex_ld,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_redirect,
  input  logic              i_md_busy,
  input  logic              i_mem_busy,
  output logic              o_pc_en,
  output logic              o_pc_sel,
  output logic [3:0]        o_en,
  output logic [3:0]        o_srsh,
  output logic [1:0]        o_state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] o_stall_cnt,
  output logic [PERF_W-1:0] o_flush_cnt,
  output logic [PERF_W-1:0] o_freeze_cnt
`endif
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(FLUSH_CYCLES - 1);

  if (FLUSH_CYCLES < 1 || PERF_W < 1) begin : g_param_chk
    $error("pipe_ctrl: FLUSH_CYCLES and PERF_W must be >= 1");
  end

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           lu_haz;
  logic           stall_ev, flush_ev, freeze_ev;

  // A load writing x0 produces nothing to wait for.
  assign lu_haz = i_ex_ld && (i_ex_rd != '0) &&
                  ((i_id_rs1_use && (i_id_rs1 == i_ex_rd)) ||
                   (i_id_rs2_use && (i_id_rs2 == i_ex_rd)));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    o_pc_en   = 1'b1;
    o_pc_sel  = 1'b0;
    o_en      = 4'b1111;
    o_srsh    = 4'b0000;
    stall_ev  = 1'b0;
    flush_ev  = 1'b0;
    freeze_ev = 1'b0;

    if (!i_rst_n) begin
      o_pc_en = 1'b0;
      o_en    = 4'b0000;
      o_srsh  = 4'b1111;
    end else if (i_mem_busy) begin
      o_pc_en   = 1'b0;
      o_en      = 4'b0000;
      freeze_ev = 1'b1;
    end else if (i_redirect) begin
      o_pc_sel = 1'b1;
      o_en     = 4'b1100;
      o_srsh   = 4'b0011;
      flush_ev = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_nxt = FLUSH;
        cnt_nxt   = RELOAD;
      end else begin
        state_nxt = RUN;
      end
    end else begin
      if (i_md_busy) begin
        o_pc_en  = 1'b0;
        o_en     = 4'b1000;
        o_srsh   = (state == FLUSH) ? 4'b0101 : 4'b0100;
        stall_ev = 1'b1;
      end else if (state == FLUSH) begin
        // ID holds a bubble here, so load-use cannot apply.
        o_en   = 4'b1110;
        o_srsh = 4'b0001;
      end else if (lu_haz) begin
        o_pc_en  = 1'b0;
        o_en     = 4'b1100;
        o_srsh   = 4'b0010;
        stall_ev = 1'b1;
      end
      if (state == FLUSH) begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CW'(1)) state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign o_state = state;

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_stall_cnt  <= '0;
      o_flush_cnt  <= '0;
      o_freeze_cnt <= '0;
    end else begin
      if (stall_ev && !(&o_stall_cnt))   o_stall_cnt  <= o_stall_cnt + 1'b1;
      if (flush_ev && !(&o_flush_cnt))   o_flush_cnt  <= o_flush_cnt + 1'b1;
      if (freeze_ev && !(&o_freeze_cnt)) o_freeze_cnt <= o_freeze_cnt + 1'b1;
    end
  end
`else
  logic unused_ev;
  assign unused_ev = stall_ev ^ flush_ev ^ freeze_ev;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed literal checks plus a randomized run checked every cycle against a behavioural model.
module tb_pipe_ctrl;
  localparam int FC = 3;
  localparam int PW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       u1 = 1'b0, u2 = 1'b0, ld = 1'b0, redir = 1'b0, md = 1'b0, mem = 1'b0;
  logic       pc_en, pc_sel;
  logic [3:0] en, srsh;
  logic [1:0] st;
`ifdef PIPE_CTRL_PERF_EN
  logic [PW-1:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

  int errors = 0;
  int checks = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_AW(5), .FLUSH_CYCLES(FC), .PERF_W(PW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rs1_use(u1), .i_id_rs2_use(u2),
    .i_ex_ld(ld), .i_ex_rd(rd), .i_redirect(redir), .i_md_busy(md), .i_mem_busy(mem),
    .o_pc_en(pc_en), .o_pc_sel(pc_sel), .o_en(en), .o_srsh(srsh), .o_state(st)
`ifdef PIPE_CTRL_PERF_EN
    , .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt), .o_freeze_cnt(freeze_cnt)
`endif
  );

  // Model: number of wrong-path cycles still to be discarded (0 = running).
  int flush_left = 0;
  int m_stall = 0, m_flush = 0, m_freeze = 0;

  always @(negedge clk) begin
    if (model_on) begin
      logic       lu, xpe, xps;
      logic [3:0] xen, xsr;
      logic [1:0] xst;
      lu  = ld && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      xst = (flush_left > 0) ? 2'd1 : 2'd0;
      xpe = 1'b1; xps = 1'b0; xen = 4'b1111; xsr = 4'b0000;
      if (!rst_n) begin
        xpe = 1'b0; xen = 4'b0000; xsr = 4'b1111;
      end else if (mem) begin
        xpe = 1'b0; xen = 4'b0000;
      end else if (redir) begin
        xps = 1'b1; xen = 4'b1100; xsr = 4'b0011;
      end else if (md) begin
        xpe = 1'b0; xen = 4'b1000; xsr = (flush_left > 0) ? 4'b0101 : 4'b0100;
      end else if (flush_left > 0) begin
        xen = 4'b1110; xsr = 4'b0001;
      end else if (lu) begin
        xpe = 1'b0; xen = 4'b1100; xsr = 4'b0010;
      end
      checks++;
      if ({en, srsh, pc_en, pc_sel, st} !== {xen, xsr, xpe, xps, xst}) begin
        errors++;
        $display("FAIL model t=%0t: got en=%b srsh=%b pc_en=%b pc_sel=%b state=%0d, want en=%b srsh=%b pc_en=%b pc_sel=%b state=%0d",
                 $time, en, srsh, pc_en, pc_sel, st, xen, xsr, xpe, xps, xst);
      end
      checks++;
      if ((en & srsh) != 4'b0000) begin
        errors++;
        $display("FAIL en_srsh_overlap t=%0t: got en&srsh=%b, want 0000", $time, en & srsh);
      end
`ifdef PIPE_CTRL_PERF_EN
      checks++;
      if ({stall_cnt, flush_cnt, freeze_cnt} !== {PW'(m_stall), PW'(m_flush), PW'(m_freeze)}) begin
        errors++;
        $display("FAIL perf t=%0t: got %0d/%0d/%0d, want %0d/%0d/%0d", $time,
                 stall_cnt, flush_cnt, freeze_cnt, m_stall, m_flush, m_freeze);
      end
`endif
      if (!rst_n) begin
        flush_left = 0; m_stall = 0; m_flush = 0; m_freeze = 0;
      end else if (mem) begin
        if (m_freeze < (1 << PW) - 1) m_freeze++;
      end else if (redir) begin
        flush_left = FC - 1;
        if (m_flush < (1 << PW) - 1) m_flush++;
      end else begin
        if ((md || (lu && flush_left == 0)) && m_stall < (1 << PW) - 1) m_stall++;
        if (flush_left > 0) flush_left--;
      end
    end
  end

  task automatic cyc(input logic r, input logic l, input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2, input logic a1, input logic a2,
                     input logic rdr, input logic m, input logic mb);
    @(posedge clk);
    #1;
    rst_n = r; ld = l; rd = d; rs1 = s1; rs2 = s2; u1 = a1; u2 = a2;
    redir = rdr; md = m; mem = mb;
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lit(input string nm, input logic [3:0] xen, input logic [3:0] xsr,
                     input logic xpe, input logic xps, input logic [1:0] xst);
    #2;
    checks++;
    if ({en, srsh, pc_en, pc_sel, st} !== {xen, xsr, xpe, xps, xst}) begin
      errors++;
      $display("FAIL %s: got en=%b srsh=%b pc_en=%b pc_sel=%b state=%0d, want en=%b srsh=%b pc_en=%b pc_sel=%b state=%0d",
               nm, en, srsh, pc_en, pc_sel, st, xen, xsr, xpe, xps, xst);
    end
  endtask

  initial begin
    // reset with arbitrary inputs
    cyc(0, 1, 3, 3, 3, 1, 1, 1, 1, 0); model_on = 1'b1; lit("reset1", 4'b0000, 4'b1111, 0, 0, 0);
    cyc(0, 0, 7, 0, 0, 0, 0, 1, 0, 1); lit("reset2", 4'b0000, 4'b1111, 0, 0, 0);
    idle(); lit("run_idle", 4'b1111, 4'b0000, 1, 0, 0);
    // load-use on rs2, then same with rd=x0
    cyc(1, 1, 5, 0, 5, 0, 1, 0, 0, 0); lit("load_use", 4'b1100, 4'b0010, 0, 0, 0);
    idle(); lit("load_use_done", 4'b1111, 4'b0000, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 0); lit("load_x0", 4'b1111, 4'b0000, 1, 0, 0);
    // redirect, flush window, restart
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); lit("redir", 4'b1100, 4'b0011, 1, 1, 0);
    idle(); lit("flush_a", 4'b1110, 4'b0001, 1, 0, 1);
    idle(); lit("flush_b", 4'b1110, 4'b0001, 1, 0, 1);
    idle(); lit("flush_end", 4'b1111, 4'b0000, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); lit("redir2", 4'b1100, 4'b0011, 1, 1, 0);
    idle(); lit("flush2_a", 4'b1110, 4'b0001, 1, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); lit("redir_in_flush", 4'b1100, 4'b0011, 1, 1, 1);
    idle(); lit("flush3_a", 4'b1110, 4'b0001, 1, 0, 1);
    idle(); lit("flush3_b", 4'b1110, 4'b0001, 1, 0, 1);
    idle(); lit("flush3_end", 4'b1111, 4'b0000, 1, 0, 0);
    // freeze beats redirect
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 1); lit("freeze", 4'b0000, 4'b0000, 0, 0, 0);
    end
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); lit("redir_after_freeze", 4'b1100, 4'b0011, 1, 1, 0);
    // md_busy inside flush, load-use ignored in flush
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); lit("md_in_flush", 4'b1000, 4'b0101, 0, 0, 1);
    cyc(1, 1, 4, 4, 0, 1, 0, 0, 0, 0); lit("lu_in_flush", 4'b1110, 4'b0001, 1, 0, 1);
    idle(); lit("flush4_end", 4'b1111, 4'b0000, 1, 0, 0);
    // md_busy beats load-use
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 9, 9, 0, 1, 0, 0, 1, 0); lit("md_over_lu", 4'b1000, 4'b0100, 0, 0, 0);
    end
    cyc(1, 1, 9, 9, 0, 1, 0, 0, 0, 0); lit("lu_after_md", 4'b1100, 4'b0010, 0, 0, 0);
    // reset mid-flush
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); lit("redir_pre_rst", 4'b1100, 4'b0011, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); lit("rst_in_flush", 4'b0000, 4'b1111, 0, 0, 1);
    idle(); lit("after_rst", 4'b1111, 4'b0000, 1, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
    cyc(1, 1, 5, 0, 5, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(); idle();
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(); #2;
    checks++;
    if ({stall_cnt, flush_cnt, freeze_cnt} !== {PW'(1), PW'(1), PW'(3)}) begin
      errors++;
      $display("FAIL perf_lit: got %0d/%0d/%0d, want 1/1/3", stall_cnt, flush_cnt, freeze_cnt);
    end
`endif
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 7) == 0));
    end
    idle();
    @(posedge clk); #7;
    model_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Hazard and flow scheduler for the 4 inter-stage pipeline registers of the core: IF/ID=0, ID/EX=1, EX/MEM=2, MEM/WB=3.
- Each of those registers has a per-stage enable and a per-stage synchronous clear (flush).
- Every cycle this block drives those enables and flushes, plus the PC enable, from load-use, redirect, multi-cycle-ALU and data-memory-wait conditions.
- It sits beside the decode stage and is the only source of stall/flush control in the core.

Parameters:
- REG_AW, 5, register-address width.
- FLUSH_CYCLES, 2, number of cycles IF/ID is cleared after a redirect, covering fetch latency. Must be >=1.
- PERF_W, 32, width of the performance counters (only with the optional feature).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_id_rs1  in  REG_AW  rs1 of the instruction in ID.
- i_id_rs2  in  REG_AW  rs2 of the instruction in ID.
- i_id_rs1_use  in  1  the ID instruction reads rs1.
- i_id_rs2_use  in  1  the ID instruction reads rs2.
- i_ex_ld  in  1  the instruction in EX is a load.
- i_ex_rd  in  REG_AW  destination register of the EX instruction.
- i_redirect  in  1  branch/jump mispredict resolved in EX.
- i_md_busy  in  1  multi-cycle mul/div in EX not yet done.
- i_mem_busy  in  1  data memory not ready; freezes the pipeline.
- o_pc_en  out  1  PC register enable.
- o_pc_sel  out  1  1 selects the redirect target for the PC.
- o_en  out  4  per-stage register enable.
- o_srsh  out  4  per-stage synchronous clear.
- o_state  out  2  FSM state, for debug.

Behaviour:
- Outputs are combinational from the state register and the current inputs, so a stall takes effect in the same cycle as its cause.
- State is updated on posedge i_clk.
- Reset (i_rst_n=0, sampled on the clock):
  - state goes to RUN and the flush counter goes to 0.
  - While reset is low: o_en=4'b0000, o_srsh=4'b1111, o_pc_en=0, o_pc_sel=0.
- Hazard definitions:
  - lu_haz = i_ex_ld & (i_ex_rd != 0) & ((i_id_rs1_use & rs1==rd) | (i_id_rs2_use & rs2==rd)).
  - A load to x0 never causes a stall.
- Condition priority, highest first: i_mem_busy, i_redirect, i_md_busy, lu_haz.
- Cycle actions (o_en / o_srsh, bit 3..0):
  - mem_busy freeze: o_en=0000, o_srsh=0000, o_pc_en=0. State and counter hold. A redirect is not latched; EX is frozen, so i_redirect stays asserted until the freeze ends.
  - redirect: o_pc_en=1, o_pc_sel=1, o_en=1100, o_srsh=0011. IF/ID and ID/EX are cleared, EX/MEM and MEM/WB advance.
    - If FLUSH_CYCLES>1: enter FLUSH and load the counter with FLUSH_CYCLES-1.
    - Otherwise stay in RUN.
  - md_busy: o_pc_en=0, o_en=1000, o_srsh=0100. PC, IF/ID and ID/EX hold; a bubble goes into EX/MEM; MEM/WB drains.
  - load-use: o_pc_en=0, o_en=1100, o_srsh=0010. PC and IF/ID hold; a bubble goes into ID/EX.
  - none: o_pc_en=1, o_pc_sel=0, o_en=1111, o_srsh=0000.
- States: RUN=0, FLUSH=1.
- RUN: apply the cycle actions above.
- FLUSH:
  - When no higher-priority condition is active: o_pc_en=1, o_pc_sel=0, o_en=1110, o_srsh=0001 (discards wrong-path fetch returns).
  - lu_haz is ignored, because ID holds a bubble.
  - i_md_busy is applied as in RUN, but bit 0 of o_srsh stays 1.
  - The counter decrements on every non-frozen cycle. When the count is 1 and decrements, next state = RUN.
  - A new i_redirect in FLUSH re-applies the redirect actions and reloads the counter to FLUSH_CYCLES-1.
- Invariant: for every bit, o_en and o_srsh are never both 1.
- Synchronous reset asserted mid-FLUSH: state returns to RUN on that edge.
- o_state reset value: 0.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined, add ports o_stall_cnt, o_flush_cnt, o_freeze_cnt (out, PERF_W each). Reset value 0.
  - o_stall_cnt increments on every load-use or md_busy stall cycle.
  - o_flush_cnt increments on every accepted redirect.
  - o_freeze_cnt increments on every mem_busy cycle.
  - All three saturate at all-ones.
- When undefined, these ports and their counters do not exist and the rest of the behaviour is identical.

Test Plan:
- Reset: hold i_rst_n=0 for 2 clocks with arbitrary inputs -> o_srsh=1111, o_en=0000, o_pc_en=0. After release with no hazards -> o_en=1111, o_pc_en=1, o_state=0.
- Load-use: i_ex_ld=1, i_ex_rd=5, i_id_rs2=5, rs2_use=1 -> o_pc_en=0, o_en=1100, o_srsh=0010 for exactly 1 cycle. Same stimulus with rd=0 -> no stall.
- Redirect with FLUSH_CYCLES=3:
  - Pulse i_redirect -> that cycle o_srsh=0011 and o_pc_sel=1.
  - Next 2 cycles o_srsh=0001 and o_state=1, then RUN.
  - A second redirect during FLUSH -> the counter restarts and 2 more FLUSH cycles follow.
- Freeze priority: i_mem_busy=1 together with i_redirect=1 for 3 cycles -> o_en=0000, o_srsh=0000. When mem_busy drops -> the redirect actions fire once.
- md_busy for 4 cycles with lu_haz=1 -> md_busy outputs (o_en=1000, o_srsh=0100) on all 4 cycles. Then 1 load-use cycle if the hazard persists.
- With PIPE_CTRL_PERF_EN: 1 load-use, 1 redirect, 3 freeze cycles -> o_stall_cnt=1, o_flush_cnt=1, o_freeze_cnt=3. A counter preloaded near all-ones saturates.
